// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path.
// Contents: parity and length encodings, FSM state type, FIFO entry layout,
// and the 3-sample majority helper.
package uart_rx_fifo_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam int unsigned RX_ENTRY_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO with show-ahead head, flush, occupancy and full/empty.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          synchronous clear, wins over push/pop
//   push/push_data write request; dropped when full unless a pop accompanies it
//   pop            remove head entry; ignored when empty
//   head_data      head entry, zero when empty
//   empty/full     occupancy flags
//   level          entry count
module uart_rx_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 11,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign level   = count;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time frame format and a status-tagged receive FIFO.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rx_data_sample             one-clk pulse at OSR x baud
//   rx_en                      receiver enable; low aborts any frame
//   rxd                        asynchronous serial input, idle high
//   data_len/par_mode/stop2    frame format, captured at start of frame
//   fifo_flush, rd_en          FIFO clear and head pop
//   rd_data/rd_perr/rd_ferr/rd_brk  show-ahead head entry
//   rx_empty/rx_full/rx_level  FIFO occupancy
//   overrun                    sticky dropped-frame flag
//   rx_busy                    frame in progress
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned OSR   = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_data_sample,
  input  logic        rx_en,
  input  logic        rxd,
  input  logic [1:0]  data_len,
  input  logic [1:0]  par_mode,
  input  logic        stop2,
  input  logic        fifo_flush,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_perr,
  output logic        rd_ferr,
  output logic        rd_brk,
  output logic        rx_empty,
  output logic        rx_full,
  output logic [AW:0] rx_level,
  output logic        overrun,
  output logic        rx_busy
);

  localparam int unsigned CW = $clog2(OSR);
  localparam int unsigned H  = OSR / 2;
  localparam logic [CW-1:0] CNT_PRE  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H);
  localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OSR - 1);

  rx_state_e     state, next_state;
  logic          rx_sync1, rxs;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic          s0, s1;
  logic [1:0]    len_q, par_q;
  logic          stop2_q;
  logic [7:0]    data_q;
  logic          perr_q, ferr_q, brk_q, pbit_q;
  logic          wait_high;
  logic          tick, start, at_vote, at_end, vote, last_bit, par_en;
  logic          push, ferr_now, brk_now;
  rx_entry_t     entry, head;
  logic          fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1 <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rx_sync1 <= rxd;
      rxs      <= rx_sync1;
    end
  end

  assign tick     = rx_en & rx_data_sample;
  assign start    = (state == ST_IDLE) & tick & ~rxs & ~wait_high;
  assign at_vote  = tick & (sample_cnt == CNT_VOTE);
  assign at_end   = tick & (sample_cnt == CNT_END);
  assign vote     = maj3(s0, s1, rxs);
  assign last_bit = (bit_cnt == ({1'b0, len_q} + 3'd4));
  assign par_en   = (par_q == PAR_EVEN) | (par_q == PAR_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!rx_en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) next_state = ST_START;
        ST_START: begin
          if (at_vote && vote) next_state = ST_IDLE;
          else if (at_end)     next_state = ST_DATA;
        end
        ST_DATA:   if (at_end && last_bit) next_state = par_en ? ST_PARITY : ST_STOP1;
        ST_PARITY: if (at_end) next_state = ST_STOP1;
        ST_STOP1: begin
          if (at_vote && !stop2_q)    next_state = ST_IDLE;
          else if (at_end && stop2_q) next_state = ST_STOP2;
        end
        ST_STOP2:  if (at_vote) next_state = ST_IDLE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy  = (state != ST_IDLE);
    push     = at_vote & (((state == ST_STOP1) & ~stop2_q) | (state == ST_STOP2));
    ferr_now = (state == ST_STOP2) ? (ferr_q | ~vote) : ~vote;
    brk_now  = (state == ST_STOP2) ? brk_q : (~vote & (data_q == '0) & ~pbit_q);
    entry    = '{brk: brk_now, ferr: ferr_now, perr: perr_q, data: data_q};
  end

  // A frame that ends with the line still low (framing error or break) must
  // see rxd return high before another start is accepted; otherwise a held
  // break line would be received as a stream of back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      len_q      <= LEN_8;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      pbit_q     <= 1'b0;
      wait_high  <= 1'b0;
    end else if (!rx_en) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      wait_high  <= 1'b0;
    end else begin
      if (push && ferr_now) wait_high <= 1'b1;
      else if (rxs)         wait_high <= 1'b0;

      if (start) begin
        sample_cnt <= CW'(1);
        bit_cnt    <= '0;
        data_q     <= '0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
        brk_q      <= 1'b0;
        pbit_q     <= 1'b0;
        len_q      <= data_len;
        par_q      <= par_mode;
        stop2_q    <= stop2;
      end else if (tick && state != ST_IDLE) begin
        sample_cnt <= (sample_cnt == CNT_END) ? '0 : sample_cnt + 1'b1;
        if (sample_cnt == CNT_PRE) s0 <= rxs;
        if (sample_cnt == CNT_MID) s1 <= rxs;
        if (sample_cnt == CNT_VOTE) begin
          case (state)
            ST_DATA:   data_q[bit_cnt] <= vote;
            ST_PARITY: begin
              pbit_q <= vote;
              perr_q <= (^data_q) ^ vote ^ (par_q == PAR_ODD);
            end
            ST_STOP1: begin
              ferr_q <= ~vote;
              brk_q  <= brk_now;
            end
            default: ;
          endcase
        end
        if (sample_cnt == CNT_END && state == ST_DATA)
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // When full, a simultaneous pop makes room, so only an unaccompanied push
  // is a dropped frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         overrun <= 1'b0;
    else if (fifo_flush)                overrun <= 1'b0;
    else if (push && fifo_full && !rd_en) overrun <= 1'b1;
  end

  uart_rx_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (RX_ENTRY_W),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (push),
    .push_data (entry),
    .pop       (rd_en),
    .head_data (head),
    .empty     (rx_empty),
    .full      (fifo_full),
    .level     (rx_level)
  );

  assign rx_full = fifo_full;
  assign rd_data = head.data;
  assign rd_perr = head.perr;
  assign rd_ferr = head.ferr;
  assign rd_brk  = head.brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int OSR    = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int TDIV   = 4;
  localparam int BITCLK = OSR * TDIV;

  logic        clk, rst_n, rx_data_sample, rx_en, rxd;
  logic [1:0]  data_len, par_mode;
  logic        stop2, fifo_flush, rd_en;
  logic [7:0]  rd_data;
  logic        rd_perr, rd_ferr, rd_brk;
  logic        rx_empty, rx_full, overrun, rx_busy;
  logic [AW:0] rx_level;

  uart_rx_fifo #(.OSR(OSR), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_sample(rx_data_sample), .rx_en(rx_en),
    .rxd(rxd), .data_len(data_len), .par_mode(par_mode), .stop2(stop2),
    .fifo_flush(fifo_flush), .rd_en(rd_en), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .rd_brk(rd_brk), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_level(rx_level), .overrun(overrun), .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rx_data_sample = 1'b0;
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 rx_data_sample = 1'b1;
      @(posedge clk);
      #1 rx_data_sample = 1'b0;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  logic        exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_clk(BITCLK);
  endtask

  // Expected FIFO entry {brk, ferr, perr, data} from the frame as sent on the line.
  function automatic logic [10:0] model_entry(input logic [7:0] b, input int nbits,
                                              input logic [1:0] par, input logic pbit,
                                              input logic s1);
    logic [7:0] d;
    logic       pe, perr, ferr, brk;
    int         ones;
    d    = b & 8'((1 << nbits) - 1);
    pe   = (par == 2'b01) || (par == 2'b10);
    ones = $countones(d) + ((pe && pbit) ? 1 : 0);
    perr = 1'b0;
    if (par == 2'b01) perr = (ones % 2) != 0;
    if (par == 2'b10) perr = (ones % 2) == 0;
    ferr = !s1;
    brk  = ferr && (d == 8'h00) && !(pe && pbit);
    return {brk, ferr, perr, d};
  endfunction

  task automatic model_push(input logic [10:0] e);
    if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits, input logic [1:0] par,
                            input logic pbit, input logic st2, input logic s1);
    data_len = 2'(nbits - 5);
    par_mode = par;
    stop2    = st2;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    if (par == 2'b01 || par == 2'b10) send_bit(pbit);
    send_bit(s1);
    if (st2) send_bit(1'b1);
    send_bit(1'b1);
    model_push(model_entry(b, nbits, par, pbit, s1));
  endtask

  task automatic check_head(input string tag);
    logic [10:0] e;
    e = (exp_q.size() == 0) ? 11'h0 : exp_q[0];
    chk({tag, " rd_data"}, 32'(rd_data), 32'(e[7:0]));
    chk({tag, " rd_perr"}, 32'(rd_perr), 32'(e[8]));
    chk({tag, " rd_ferr"}, 32'(rd_ferr), 32'(e[9]));
    chk({tag, " rd_brk"},  32'(rd_brk),  32'(e[10]));
  endtask

  task automatic check_status(input string tag);
    chk({tag, " level"},   32'(rx_level), 32'(exp_q.size()));
    chk({tag, " empty"},   32'(rx_empty), 32'(exp_q.size() == 0));
    chk({tag, " full"},    32'(rx_full),  32'(exp_q.size() == DEPTH));
    chk({tag, " overrun"}, 32'(overrun),  32'(exp_ovr));
    chk({tag, " busy"},    32'(rx_busy),  32'(0));
    check_head(tag);
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one(tag);
    check_status({tag, " drained"});
  endtask

  task automatic flush;
    fifo_flush = 1'b1;
    wait_clk(1);
    fifo_flush = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       seen_busy, pbit, good;
    int         nb;
    logic [1:0] pm;

    rst_n = 1'b0; rxd = 1'b1; rx_en = 1'b1; data_len = 2'b11; par_mode = 2'b00;
    stop2 = 1'b0; fifo_flush = 1'b0; rd_en = 1'b0;
    wait_clk(3);
    chk("reset busy", 32'(rx_busy), 0);
    chk("reset empty", 32'(rx_empty), 1);
    rst_n = 1'b1;
    wait_clk(2);
    check_status("reset");

    // 8N1 0xA5
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    check_status("8N1 A5");
    chk("8N1 A5 level1", 32'(rx_level), 1);
    drain("8N1 A5");

    // 7E2 0x35, correct then wrong parity bit
    send_frame(8'h35, 7, 2'b01, 1'b0, 1'b1, 1'b1);
    chk("7E2 data", 32'(rd_data), 32'h35);
    chk("7E2 perr0", 32'(rd_perr), 0);
    pop_one("7E2 p0");
    send_frame(8'h35, 7, 2'b01, 1'b1, 1'b1, 1'b1);
    chk("7E2 perr1", 32'(rd_perr), 1);
    pop_one("7E2 p1");

    // 1.5-tick glitch on the idle line
    rxd = 1'b0;
    wait_clk(6);
    rxd = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_clk(1);
      if (rx_busy) seen_busy = 1'b1;
    end
    chk("glitch busy rose", 32'(seen_busy), 1);
    wait_clk(BITCLK);
    check_status("glitch");

    // DEPTH+1 frames, no reads
    for (int i = 0; i <= DEPTH; i++) send_frame(8'($urandom), 8, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("ovr full", 32'(rx_full), 1);
    chk("ovr overrun", 32'(overrun), 1);
    check_status("ovr");
    drain("ovr");
    chk("ovr sticky", 32'(overrun), 1);
    flush;
    check_status("ovr flushed");

    // Break: line low for 12 bit times
    data_len = 2'b11; par_mode = 2'b00; stop2 = 1'b0;
    rxd = 1'b0;
    wait_clk(12 * BITCLK);
    rxd = 1'b1;
    wait_clk(2 * BITCLK);
    model_push({1'b1, 1'b1, 1'b0, 8'h00});
    check_status("break");
    pop_one("break");

    // rx_en dropped mid data bit 3
    send_frame(8'h5A, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    b = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rxd = b[3];
    wait_clk(BITCLK / 2);
    chk("rxen busy before", 32'(rx_busy), 1);
    rx_en = 1'b0;
    wait_clk(2);
    chk("rxen busy low", 32'(rx_busy), 0);
    wait_clk(BITCLK / 2);
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_en = 1'b1;
    wait_clk(2);
    check_status("rxen kept");
    send_frame(8'hC3, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    check_status("rxen next");
    drain("rxen");

    // Randomised frame formats and status
    for (int n = 0; n < 24; n++) begin
      nb   = $urandom_range(5, 8);
      pm   = 2'($urandom_range(0, 3));
      b    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      good = (pm == 2'b10) ? ~^(b & 8'((1 << nb) - 1)) : ^(b & 8'((1 << nb) - 1));
      pbit = ($urandom_range(0, 3) == 0) ? ~good : good;
      send_frame(b, nb, pm, pbit, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
      check_status($sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) pop_one($sformatf("rnd%0d pop", n));
    end
    drain("rnd");
    flush;

    // rd_en while empty is ignored
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    check_status("empty pop");

    // Reset mid-frame
    send_frame(8'h81, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    wait_clk(2);
    exp_q.delete();
    exp_ovr = 1'b0;
    chk("midrst busy", 32'(rx_busy), 0);
    rxd = 1'b1;
    rst_n = 1'b1;
    wait_clk(BITCLK);
    check_status("midrst");
    send_frame(8'h7E, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    check_status("after rst");
    drain("after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
